// File: rtl/control_bus.sv
// Bus transfer sequencer: turns a register-to-register move command into a
// DRIVE / CAPTURE / RELEASE strobe sequence on the shared data bus.
module control_bus #(
    parameter int N_REG = 4,
    parameter int W     = 8,
    parameter int SW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SW-1:0]    cmd_src,
    input  logic [SW-1:0]    cmd_dst,
    output logic [N_REG-1:0] load,
    output logic [N_REG-1:0] save,
    input  logic [W-1:0]     bus_in,
    output logic [W-1:0]     dato,
    output logic             done,
    output logic             error,
    output logic [7:0]       n_transf
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DRIVE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    // Handshake: a command transfers on a rising edge with cmd_valid && cmd_ready;
    // cmd_ready is high exactly in IDLE, and cmd_* are ignored otherwise.
    logic [1:0]    state;
    logic [SW-1:0] dst_q;
    logic          cmd_bad;
    logic          accept;

    function automatic logic [N_REG-1:0] onehot(input logic [SW-1:0] idx);
        logic [N_REG-1:0] v;
        v = '0;
        for (int i = 0; i < N_REG; i++) begin
            v[i] = (idx == SW'(i));
        end
        return v;
    endfunction

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_bad   = (cmd_src == cmd_dst) ||
                       (32'(cmd_src) >= 32'(N_REG)) ||
                       (32'(cmd_dst) >= 32'(N_REG));

    // Strobes are registered and sequenced so save always drops a cycle
    // before load, giving the destination hold time on a still-driven bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dst_q    <= '0;
            load     <= '0;
            save     <= '0;
            dato     <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            n_transf <= 8'd0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_bad) begin
                            error <= 1'b1;
                        end else begin
                            dst_q <= cmd_dst;
                            load  <= onehot(cmd_src);
                            state <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    save  <= onehot(dst_q);
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    save  <= '0;
                    dato  <= bus_in;
                    state <= RELEASE;
                end
                RELEASE: begin
                    load     <= '0;
                    done     <= 1'b1;
                    n_transf <= n_transf + 8'd1;
                    state    <= IDLE;
                end
                default: begin
                    load  <= '0;
                    save  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_bus.sv
// Directed bench for control_bus: reset, single and back-to-back moves,
// rejection, counter wrap, plus a strobe-invariant monitor.
module tb_control_bus;

    localparam int N_REG = 4;
    localparam int W     = 8;
    localparam int SW    = 3;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [SW-1:0]    cmd_src;
    logic [SW-1:0]    cmd_dst;
    logic [N_REG-1:0] load;
    logic [N_REG-1:0] save;
    logic [W-1:0]     bus_in;
    logic [W-1:0]     dato;
    logic             done;
    logic             error;
    logic [7:0]       n_transf;

    int n_compared = 0;
    int n_mismatch = 0;

    logic [W-1:0]     regs [N_REG];
    logic [7:0]       exp_n;
    logic [W-1:0]     exp_dato;
    logic [N_REG-1:0] prev_load;
    logic [N_REG-1:0] prev_save;

    control_bus #(.N_REG(N_REG), .W(W), .SW(SW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_src  (cmd_src),
        .cmd_dst  (cmd_dst),
        .load     (load),
        .save     (save),
        .bus_in   (bus_in),
        .dato     (dato),
        .done     (done),
        .error    (error),
        .n_transf (n_transf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus model: the register whose load bit is set drives the bus.
    always_comb begin
        bus_in = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (load[i]) bus_in = bus_in | regs[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_REG-1:0] oh(input int idx);
        logic [N_REG-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Strobe invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_load = '0;
            prev_save = '0;
        end else begin
            check("mon_load_onehot", 32'($countones(load) <= 1), 1);
            check("mon_save_onehot", 32'($countones(save) <= 1), 1);
            check("mon_save_needs_other_load",
                  32'((save == 0) || ((load != 0) && ((save & load) == 0))), 1);
            if (prev_load != 0 && load == 0)
                check("mon_save_falls_first", 32'(prev_save == 0), 1);
            prev_load = load;
            prev_save = save;
        end
    end

    task automatic wait_ready();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", 32'(cmd_ready), 1);
    endtask

    task automatic do_move(input int s, input int d);
        wait_ready();
        cmd_src   = SW'(s);
        cmd_dst   = SW'(d);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("drive_load", 32'(load), 32'(oh(s)));
        check("drive_save", 32'(save), 0);
        @(negedge clk);
        check("capture_load", 32'(load), 32'(oh(s)));
        check("capture_save", 32'(save), 32'(oh(d)));
        @(negedge clk);
        exp_dato = regs[s];
        check("release_load", 32'(load), 32'(oh(s)));
        check("release_save", 32'(save), 0);
        check("release_dato", 32'(dato), 32'(exp_dato));
        @(negedge clk);
        exp_n = exp_n + 8'd1;
        check("done_load", 32'(load), 0);
        check("done_pulse", 32'(done), 1);
        check("done_ready", 32'(cmd_ready), 1);
        check("done_count", 32'(n_transf), 32'(exp_n));
    endtask

    task automatic do_reject(input int s, input int d);
        wait_ready();
        cmd_src   = SW'(s);
        cmd_dst   = SW'(d);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("rej_error", 32'(error), 1);
        check("rej_load", 32'(load), 0);
        check("rej_save", 32'(save), 0);
        check("rej_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        check("rej_error_drop", 32'(error), 0);
        check("rej_count", 32'(n_transf), 32'(exp_n));
        check("rej_dato", 32'(dato), 32'(exp_dato));
        check("rej_no_done", 32'(done), 0);
    endtask

    initial begin
        int s;
        int d;
        regs[0] = 8'b1001_0100;
        regs[1] = 8'b0001_0110;
        regs[2] = 8'h5a;
        regs[3] = 8'hc3;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        exp_n     = 8'd0;
        exp_dato  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_load", 32'(load), 0);
        check("rst_save", 32'(save), 0);
        check("rst_dato", 32'(dato), 0);
        check("rst_done_err", {30'd0, done, error}, 0);
        check("rst_count", 32'(n_transf), 0);
        @(negedge clk) rst_n = 1'b1;

        // Basic move 0 -> 1
        do_move(0, 1);
        check("basic_dato", 32'(dato), 32'h94);
        check("basic_count", 32'(n_transf), 1);

        // Reset in the middle of CAPTURE
        wait_ready();
        cmd_src = SW'(2); cmd_dst = SW'(0); cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_save", 32'(save), 32'(oh(0)));
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_load", 32'(load), 0);
        check("async_rst_save", 32'(save), 0);
        check("async_rst_count", 32'(n_transf), 0);
        check("async_rst_ready", 32'(cmd_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        exp_n = 8'd0;
        exp_dato = '0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 1);
        check("post_rst_no_done", 32'(done), 0);

        // Back-to-back with cmd_valid held: 1 -> 0 then 2 -> 3
        @(negedge clk);
        cmd_src = SW'(1); cmd_dst = SW'(0); cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_src = SW'(2); cmd_dst = SW'(3);
        @(negedge clk);
        check("b2b_first_load", 32'(load), 32'(oh(1)));
        check("b2b_busy", 32'(cmd_ready), 0);
        repeat (3) @(negedge clk);
        check("b2b_first_done", 32'(done), 1);
        check("b2b_first_dato", 32'(dato), 32'h16);
        check("b2b_first_count", 32'(n_transf), 1);
        check("b2b_first_load_off", 32'(load), 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_load", 32'(load), 32'(oh(2)));
        @(negedge clk);
        check("b2b_second_save", 32'(save), 32'(oh(3)));
        repeat (2) @(negedge clk);
        check("b2b_second_done", 32'(done), 1);
        check("b2b_second_dato", 32'(dato), 32'h5a);
        check("b2b_second_count", 32'(n_transf), 2);
        exp_n = 8'd2;
        exp_dato = 8'h5a;

        // Rejections
        do_reject(2, 2);
        do_reject(5, 0);
        do_reject(1, 7);

        // 256 random valid moves: counter wraps back to its start value
        for (int k = 0; k < 256; k++) begin
            s = $urandom_range(0, N_REG - 1);
            d = (s + $urandom_range(1, N_REG - 1)) % N_REG;
            regs[s] = 8'($urandom_range(0, 255));
            do_move(s, d);
        end
        check("wrap_count", 32'(n_transf), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/control_bus.md
# control_bus

Bus transfer sequencer for the control unit's shared 8-bit data bus. It accepts a register-to-register move command and drives the per-register `load` strobes (register puts its value on the bus) and `save` strobes (register captures the bus). It also samples the bus itself, so every transferred value is visible to the control unit. Strobes are sequenced so that at most one register drives the bus at any time, and `save` always drops while the source is still driving.

## Interface
- `N_REG`, default 4: number of bus registers; range 2..16.
- `W`, default 8: bus width in bits.
- `SW`, default 2: register index width; must satisfy `2**SW >= N_REG`.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `cmd_valid`, input, 1: a move command is present.
- `cmd_ready`, output, 1: the block can accept a command (high only in IDLE).
- `cmd_src`, input, SW: index of the source register (it drives the bus).
- `cmd_dst`, input, SW: index of the destination register (it captures the bus).
- `load`, output, N_REG: one-hot bus-drive enable, one bit per register.
- `save`, output, N_REG: one-hot capture strobe, one bit per register.
- `bus_in`, input, W: the resolved shared bus value.
- `dato`, output, W: last value sampled from the bus.
- `done`, output, 1: one-cycle pulse when a move completes.
- `error`, output, 1: one-cycle pulse when a command is rejected.
- `n_transf`, output, 8: count of completed moves; wraps at 255 to 0.

## Operation
- Handshake: a command is accepted on a rising edge where `cmd_valid && cmd_ready`. `cmd_src` and `cmd_dst` are latched internally at that edge. Inputs are ignored in every other state.
- Rejection: the command is rejected if `cmd_src == cmd_dst`, or if either index is `>= N_REG`.
  - On rejection, the FSM stays in IDLE and `error` pulses for the next cycle.
  - No strobe is asserted, and `dato` and `n_transf` are unchanged.
- States: IDLE → DRIVE → CAPTURE → RELEASE → IDLE. One cycle in each non-IDLE state.
  - IDLE: `cmd_ready` = 1, `load` = 0, `save` = 0.
  - DRIVE: `load[src]` = 1. Bus settle cycle; no capture.
  - CAPTURE: `load[src]` = 1, `save[dst]` = 1. At the closing edge, `dato <= bus_in`.
  - RELEASE: `load[src]` = 1, `save` = 0. Provides destination hold time.
  - Return to IDLE: `load` = 0, `done` pulses for 1 cycle, `n_transf` increments.
- Invariants, holding in every cycle:
  - `popcount(load) <= 1` and `popcount(save) <= 1`.
  - `save` is never high unless `load` of a different register is also high.
- All strobe outputs are registered (no combinational path from `cmd_*` to `load`/`save`).
- Counter: `n_transf` is an 8-bit unsigned count; 255 + 1 = 0, with no flag.
- Bus contents are not checked. Whatever `bus_in` holds at the CAPTURE edge is stored in `dato`.

## Timing
- Reset (`rst_n` low, asynchronous): state = IDLE, `cmd_ready` = 1, and `load`, `save`, `dato`, `done`, `error`, `n_transf` all = 0.
- Reset mid-move: strobes drop immediately (without waiting for a clock edge). The move is abandoned and `n_transf` is not incremented.
- Latency, with the accept edge as t0:
  - DRIVE during t0→t1.
  - CAPTURE during t1→t2; `dato` is updated at t2.
  - RELEASE during t2→t3.
  - `done` = 1 and `cmd_ready` = 1 during t3→t4.
- Throughput: a new command may be accepted at t4, i.e. the edge that closes the `done` cycle. Back-to-back moves therefore start every 4 cycles, with one idle/done cycle between `load` windows.
- Rejection: `error` = 1 during t0→t1. `cmd_ready` stays 1, so another command may be accepted at t1.
- A command held valid while `cmd_ready` = 0 is taken at the next IDLE edge, not dropped.

## Test plan
- Reset: assert `rst_n` = 0 mid-CAPTURE → `load`/`save` go to 0 asynchronously, `n_transf` = 0, and `cmd_ready` = 1 after release.
- Basic move: src = 0, dst = 1, bench bus model returns 8'b10010100 while `load[0]` is high.
  - Required: `load` = 0001 for 3 cycles, `save` = 0010 for exactly the middle cycle.
  - Required: `dato` = 8'h94, `done` at t3, `n_transf` = 1.
- Back-to-back: src = 1/dst = 0 with value 8'b00010110, then src = 2/dst = 3, both `cmd_valid` held continuously.
  - Required: accepts at t0 and t4, never two `load` bits set, `dato` = 8'h16 after the first move, `n_transf` = 2.
- Reject: src = dst = 2 → `error` pulses for 1 cycle, no strobes, `cmd_ready` stays 1. Then src = 5 with N_REG = 4 → `error` pulses again.
- Wrap: perform 256 valid moves → `n_transf` goes 255 → 0, with `done` pulsing on every move.
- Invariant check: a concurrent monitor over a random command stream confirms `popcount(load) <= 1`, `popcount(save) <= 1`, and that `save` falls at least one cycle before `load`.
